ntt_bank_agu: RTL

- Access initiator for the NTT coefficient data banks: the bank is the responder, this block drives its read port (A2/REN), write port (A1/WEN) and EN.
- Sweeps every bank address once per NTT stage and issues read requests.
- Replays each read address as the write-back address after the read-plus-butterfly pipeline latency, giving in-place update.
- Sequences all stages and prevents a read-after-write hazard at stage boundaries by draining the pipeline first.
- One instance drives all banks in lockstep, all banks sharing the same address.

---
 rtl/ntt_bank_agu_if.sv | 28 ++
 rtl/ntt_bank_agu.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ntt_bank_agu_if.sv
// Bank-port and control bundle of the NTT address generator.
// The generator takes the master side; the data banks and sequencer take the slave side.
interface ntt_bank_agu_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  i_start;
   logic                  o_busy;
   logic                  o_done;
   logic [2:0]            o_stage;
   logic [ADDR_WIDTH-1:0] o_rd_addr;
   logic                  o_ren;
   logic                  o_bf_valid;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic                  o_wen;
   logic                  o_en;

   modport master (
      input  i_start,
      output o_busy, o_done, o_stage, o_rd_addr, o_ren,
             o_bf_valid, o_wr_addr, o_wen, o_en
   );

   modport slave (
      output i_start,
      input  o_busy, o_done, o_stage, o_rd_addr, o_ren,
             o_bf_valid, o_wr_addr, o_wen, o_en
   );
endinterface

// File: rtl/ntt_bank_agu.sv
// In-place NTT bank address generator: sweeps every address per stage, replays reads as
// write-backs after the butterfly latency, and drains the pipeline between stages.
module ntt_bank_agu #(
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 64,
   parameter int NUM_STAGES = 6,
   parameter int BF_LAT     = 4
) (
   input  logic           clk,
   input  logic           rst,
   ntt_bank_agu_if.master bus
);
   localparam int WR_DLY = BF_LAT + 1;
   localparam int DCNT_W = $clog2(WR_DLY + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [DCNT_W-1:0]     LAST_DRAIN = DCNT_W'(WR_DLY - 1);
   localparam logic [2:0]            LAST_STAGE = 3'(NUM_STAGES - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_nextCnt;
   logic [DCNT_W-1:0]     r_drainCnt;
   logic [DCNT_W-1:0]     w_nextDrainCnt;
   logic [2:0]            r_stage;
   logic [2:0]            w_nextStage;
   logic                  w_ren;
   logic [2:0]            w_rotAmt;
   logic [ADDR_WIDTH-1:0] w_rdAddr;

   logic [ADDR_WIDTH-1:0] r_dlyAddr [WR_DLY];
   logic [WR_DLY-1:0]     r_dlyValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_drainCnt <= '0;
         r_stage    <= '0;
      end else begin
         r_state    <= w_nextState;
         r_cnt      <= w_nextCnt;
         r_drainCnt <= w_nextDrainCnt;
         r_stage    <= w_nextStage;
      end
   end

   // The drain ends on the cycle carrying the stage's final write, so the next read follows it directly.
   always_comb begin
      w_nextState    = r_state;
      w_nextCnt      = r_cnt;
      w_nextDrainCnt = r_drainCnt;
      w_nextStage    = r_stage;
      w_ren          = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_start) begin
               w_nextState    = READ;
               w_nextCnt      = '0;
               w_nextDrainCnt = '0;
               w_nextStage    = '0;
            end
         end
         READ: begin
            w_ren     = 1'b1;
            w_nextCnt = r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
               w_nextCnt      = '0;
               w_nextDrainCnt = '0;
               w_nextState    = DRAIN;
            end
         end
         DRAIN: begin
            if (r_drainCnt == LAST_DRAIN) begin
               w_nextDrainCnt = '0;
               if (r_stage == LAST_STAGE) begin
                  w_nextState = DONE;
               end else begin
                  w_nextStage = r_stage + 1'b1;
                  w_nextState = READ;
               end
            end else begin
               w_nextDrainCnt = r_drainCnt + 1'b1;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Rotating the sweep counter by the stage index gives each stage its butterfly stride.
   always_comb begin
      w_rotAmt = 3'(int'(r_stage) % ADDR_WIDTH);
      w_rdAddr = (r_cnt << w_rotAmt) | (r_cnt >> (ADDR_WIDTH - int'(w_rotAmt)));
   end

   // Addresses only advance alongside a valid bit, so the write address holds between bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dlyValid <= '0;
         for (int i = 0; i < WR_DLY; i++) begin
            r_dlyAddr[i] <= '0;
         end
      end else begin
         r_dlyValid <= {r_dlyValid[WR_DLY-2:0], w_ren};
         if (w_ren) begin
            r_dlyAddr[0] <= w_rdAddr;
         end
         for (int i = 1; i < WR_DLY; i++) begin
            if (r_dlyValid[i-1]) begin
               r_dlyAddr[i] <= r_dlyAddr[i-1];
            end
         end
      end
   end

   assign bus.o_busy     = (r_state != IDLE);
   assign bus.o_done     = (r_state == DONE);
   assign bus.o_stage    = r_stage;
   assign bus.o_rd_addr  = w_rdAddr;
   assign bus.o_ren      = w_ren;
   assign bus.o_bf_valid = r_dlyValid[0];
   assign bus.o_wr_addr  = r_dlyAddr[WR_DLY-1];
   assign bus.o_wen      = r_dlyValid[WR_DLY-1];
   assign bus.o_en       = w_ren | r_dlyValid[WR_DLY-1];
endmodule
